wb_regfile: RTL and testbench

//  Writeback-side consumer of the MEM/WB pipeline register: 32-entry integer register file.

---
 rtl/wb_regfile.sv | 89 ++++++++
 tb/tb_wb_regfile.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/wb_regfile.sv
// wb_regfile: 32-entry integer register file on the MEM/WB writeback side.
// Two bypassed read ports, a RAW scoreboard with stall, and a retired-write counter.
module wb_regfile #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_en,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic [XLEN-1:0]  rs1_data,
  output logic [XLEN-1:0]  rs2_data,
  input  logic             issue_valid,
  input  logic             issue_wb,
  input  logic [4:0]       issue_rd,
  output logic             stall,
  output logic [31:0]      busy_mask,
  output logic [CNT_W-1:0] wr_count
);

  logic [XLEN-1:0]  r_regs [32];
  logic [31:1]      r_busy;
  logic [CNT_W-1:0] r_cnt;

  logic        w_wr;
  logic [31:0] w_busy;
  logic        w_byp1;
  logic        w_byp2;
  logic        w_hz1;
  logic        w_hz2;
  logic        w_issue;

  assign w_wr    = wb_en && (wb_rd != 5'd0);
  assign w_busy  = {r_busy, 1'b0};
  assign w_byp1  = wb_en && (wb_rd == rs1_addr);
  assign w_byp2  = wb_en && (wb_rd == rs2_addr);
  assign w_hz1   = (rs1_addr != 5'd0) && w_busy[rs1_addr] && !w_byp1;
  assign w_hz2   = (rs2_addr != 5'd0) && w_busy[rs2_addr] && !w_byp2;
  assign w_issue = issue_valid && !stall && issue_wb;

  assign stall     = w_hz1 || w_hz2;
  assign busy_mask = w_busy;
  assign wr_count  = r_cnt;

  // Read ports: x0 is hardwired, a same-cycle commit is forwarded.
  always_comb begin
    rs1_data = r_regs[rs1_addr];
    rs2_data = r_regs[rs2_addr];
    if (w_byp1) rs1_data = wb_data;
    if (w_byp2) rs2_data = wb_data;
    if (rs1_addr == 5'd0) rs1_data = '0;
    if (rs2_addr == 5'd0) rs2_data = '0;
  end

  // Register array: commit writeback, drop writes to x0.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (w_wr) begin
      r_regs[wb_rd] <= wb_data;
    end
  end

  // Scoreboard: a new producer wins over a retiring one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy <= '0;
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (w_issue && (issue_rd == 5'(r)))
          r_busy[r] <= 1'b1;
        else if (wb_en && (wb_rd == 5'(r)))
          r_busy[r] <= 1'b0;
      end
    end
  end

  // Retired-write counter, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset)
      r_cnt <= '0;
    else if (w_wr && (r_cnt != '1))
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: directed and random checks of wb_regfile
// against a plain array-based reference model.
module tb_wb_regfile;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             wb_en;
  logic [4:0]       wb_rd;
  logic [XLEN-1:0]  wb_data;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic             issue_valid;
  logic             issue_wb;
  logic [4:0]       issue_rd;
  logic             stall;
  logic [31:0]      busy_mask;
  logic [CNT_W-1:0] wr_count;

  wb_regfile #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .issue_valid(issue_valid), .issue_wb(issue_wb),
    .issue_rd(issue_rd), .stall(stall),
    .busy_mask(busy_mask), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [XLEN-1:0] m_regs [32];
  bit              m_busy [32];
  int              m_cnt;

  logic [XLEN-1:0] s_rs1, s_rs2;
  logic            s_stall;
  logic [31:0]     s_mask;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // One clock: drive, check combinational outputs, advance model.
  task automatic cyc(input bit rst, input bit we, input logic [4:0] wrd,
                     input logic [XLEN-1:0] wdat,
                     input logic [4:0] a1, input logic [4:0] a2,
                     input bit iv, input bit iw, input logic [4:0] ird);
    logic [XLEN-1:0] e1, e2;
    logic [31:0]     emask;
    bit              est;
    reset = rst; wb_en = we; wb_rd = wrd; wb_data = wdat;
    rs1_addr = a1; rs2_addr = a2;
    issue_valid = iv; issue_wb = iw; issue_rd = ird;
    @(negedge clk);
    e1 = (a1 == 0) ? '0 : (we && wrd == a1) ? wdat : m_regs[a1];
    e2 = (a2 == 0) ? '0 : (we && wrd == a2) ? wdat : m_regs[a2];
    est = (a1 != 0 && m_busy[a1] && !(we && wrd == a1)) ||
          (a2 != 0 && m_busy[a2] && !(we && wrd == a2));
    for (int i = 0; i < 32; i++) emask[i] = m_busy[i];
    s_rs1 = rs1_data; s_rs2 = rs2_data;
    s_stall = stall; s_mask = busy_mask;
    chk("rs1_data", rs1_data, e1);
    chk("rs2_data", rs2_data, e2);
    chk("stall", stall, est);
    chk("busy_mask", busy_mask, emask);
    chk("wr_count", wr_count, m_cnt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_reset();
    end else begin
      for (int r = 1; r < 32; r++) begin
        if (iv && !est && iw && ird == r) m_busy[r] = 1'b1;
        else if (we && wrd == r) m_busy[r] = 1'b0;
      end
      if (we && wrd != 0) begin
        m_regs[wrd] = wdat;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  initial begin
    m_reset();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rst_mask", busy_mask, 32'h0);
    chk("rst_cnt", wr_count, 0);

    cyc(0, 1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0);
    chk("t2_bypass", s_rs1, 32'hDEADBEEF);
    cyc(0, 0, 0, 0, 5, 0, 0, 0, 0);
    chk("t2_array", s_rs1, 32'hDEADBEEF);

    cyc(0, 1, 0, 32'h1234, 0, 0, 0, 0, 0);
    chk("t3_x0_read", s_rs1, 32'h0);
    chk("t3_cnt", wr_count, 1);

    cyc(0, 0, 0, 0, 0, 0, 1, 1, 7);
    cyc(0, 0, 0, 0, 0, 7, 0, 0, 0);
    chk("t4_stall", s_stall, 1);
    cyc(0, 1, 7, 32'h77, 0, 7, 0, 0, 0);
    chk("t4_nostall", s_stall, 0);
    chk("t4_busy7", busy_mask[7], 0);

    cyc(0, 1, 9, 32'h99, 0, 0, 1, 1, 9);
    chk("t5_busy9", busy_mask[9], 1);
    cyc(0, 0, 0, 0, 9, 0, 1, 1, 10);
    chk("t5_stalled", s_stall, 1);
    chk("t5_busy10", busy_mask[10], 0);

    for (int i = 0; i < 17; i++)
      cyc(0, 1, 1, 32'(i), 0, 0, 0, 0, 0);
    chk("t6_sat", wr_count, 15);
    cyc(0, 1, 0, 32'h5, 0, 0, 0, 0, 0);
    chk("t6_x0", wr_count, 15);

    cyc(1, 1, 3, 32'hAB, 0, 0, 1, 1, 4);
    chk("t1_cnt", wr_count, 0);
    chk("t1_mask", busy_mask, 32'h0);
    cyc(0, 0, 0, 0, 5, 1, 0, 0, 0);
    chk("t1_rs1", s_rs1, 32'h0);
    chk("t1_rs2", s_rs2, 32'h0);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) == 0),
          ($urandom_range(0, 2) == 0),
          5'($urandom_range(0, 7)),
          $urandom(),
          5'($urandom_range(0, 7)),
          5'($urandom_range(0, 7)),
          ($urandom_range(0, 1) == 1),
          ($urandom_range(0, 3) != 0),
          5'($urandom_range(0, 7)));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
